// File: rtl/linear_layer_fifo_srl_fwft.sv
// Shift-register FIFO with a registered first-word-fall-through output stage.
// Storage is DEPTH SRL entries plus the output register, so capacity is DEPTH+1.
// Consumers see only registered data/valid; the SRL read mux never reaches if_dout
// combinationally.
// Optional feature: define LINEAR_LAYER_FIFO_OCCUPANCY_EN to add the if_num_data
// occupancy output (cnt + out_valid).
// Constraints: ADDR_WIDTH >= 1, 1 <= DEPTH <= 2**ADDR_WIDTH.
module linear_layer_fifo_srl_fwft #(
  parameter int unsigned DATA_WIDTH = 304,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // Write side
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
`ifdef LINEAR_LAYER_FIFO_OCCUPANCY_EN
  output logic [ADDR_WIDTH:0]   if_num_data,
`endif
  // Read side
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int unsigned   CntW     = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // SRL storage: entry 0 is the newest, entry cnt-1 the oldest. Not reset.
  logic [DATA_WIDTH-1:0] srl_q [DEPTH];

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  push;
  logic                  pop;
  logic                  refill;
  logic                  cnt_zero;
  logic                  shift_en;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] srl_head;

  // Full is taken from the registered count only, so a same-cycle pop never
  // opens a slot for a same-cycle write.
  assign if_full_n  = (cnt_q < DepthCnt);
  assign if_empty_n = out_valid_q;
  assign if_dout    = out_data_q;

`ifdef LINEAR_LAYER_FIFO_OCCUPANCY_EN
  assign if_num_data = cnt_q + CntW'(out_valid_q);
`endif

  assign push     = if_write & if_write_ce & if_full_n;
  assign pop      = if_read & if_read_ce & out_valid_q;
  // Output register loads this edge when it is empty or being consumed.
  assign refill   = ~out_valid_q | pop;
  assign cnt_zero = (cnt_q == '0);
  // A push into an empty SRL that refills the output register bypasses the SRL.
  assign shift_en = push & ~(refill & cnt_zero);
  assign raddr    = ADDR_WIDTH'(cnt_q - CntW'(1));

  // Read mux selecting the oldest SRL entry (value is unused when cnt is zero).
  always_comb begin
    srl_head = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_WIDTH'(i)) begin
        srl_head = srl_q[i];
      end
    end
  end

  // Next-state for occupancy count and the FWFT output register.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (refill) begin
      if (!cnt_zero) begin
        out_data_d  = srl_head;
        out_valid_d = 1'b1;
        // With a simultaneous push the SRL shifts in and the count holds.
        if (!push) begin
          cnt_d = cnt_q - CntW'(1);
        end
      end else if (push) begin
        out_data_d  = if_din;
        out_valid_d = 1'b1;
      end else begin
        // Drained: drop valid, keep the last data value.
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // SRL shift: new data enters at entry 0, older entries move up.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      srl_q[0] <= if_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_linear_layer_fifo_srl_fwft.sv
// Self-checking bench for linear_layer_fifo_srl_fwft (DATA_WIDTH=304, DEPTH=2).
// A queue-based scoreboard holds accepted writes; popped entries are compared
// with if_dout, and flags/head are checked against the queue after every edge.
module tb_linear_layer_fifo_srl_fwft;

  localparam int unsigned DW    = 304;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CAP   = DEPTH + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
`ifdef LINEAR_LAYER_FIFO_OCCUPANCY_EN
  logic [AW:0]   if_num_data;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DW-1:0] sb [$];

  linear_layer_fifo_srl_fwft #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_write_ce(if_write_ce),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
`ifdef LINEAR_LAYER_FIFO_OCCUPANCY_EN
    .if_num_data(if_num_data),
`endif
    .if_read_ce (if_read_ce),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Flags and head compared against the scoreboard occupancy.
  task automatic check_state(input string tag);
    check({tag, "_empty_n"}, DW'(if_empty_n), DW'(sb.size() > 0));
    check({tag, "_full_n"}, DW'(if_full_n), DW'(sb.size() < CAP));
    if (sb.size() > 0) check({tag, "_head"}, if_dout, sb[0]);
`ifdef LINEAR_LAYER_FIFO_OCCUPANCY_EN
    check({tag, "_num_data"}, DW'(if_num_data), DW'(sb.size()));
`endif
  endtask

  // Drive one cycle of stimulus, advance the model over the edge, then check.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic wce, input logic rce);
    bit            acc;
    bit            popped;
    logic [DW-1:0] exp;
    if_write    = w;
    if_din      = d;
    if_read     = r;
    if_write_ce = wce;
    if_read_ce  = rce;
    acc    = w && wce && (sb.size() < CAP);
    popped = r && rce && (sb.size() > 0);
    if (popped) begin
      exp = sb.pop_front();
      check({tag, "_pop_data"}, if_dout, exp);
    end
    @(posedge clk);
    if (acc) sb.push_back(d);
    #1;
    check_state(tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    if_write_ce = 1'b1;
    if_write    = 1'b1;
    if_din      = DW'(32'hFF);
    if_read_ce  = 1'b1;
    if_read     = 1'b0;

    // Reset held with a write request: nothing may be accepted.
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_empty_n", DW'(if_empty_n), '0);
      check("rst_full_n", DW'(if_full_n), DW'(1));
      check("rst_dout", if_dout, '0);
`ifdef LINEAR_LAYER_FIFO_OCCUPANCY_EN
      check("rst_num_data", DW'(if_num_data), '0);
`endif
    end
    if_write = 1'b0;
    #2 reset_n = 1'b1;
    step("post_rst", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step("post_rst2", 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Single write bypasses the SRL.
    step("single_wr", 1'b1, DW'(32'hA1), 1'b0, 1'b1, 1'b1);
    step("single_rd", 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Fill to capacity, a fourth write is dropped.
    step("fill_a1", 1'b1, DW'(32'hA1), 1'b0, 1'b1, 1'b1);
    step("fill_a2", 1'b1, DW'(32'hA2), 1'b0, 1'b1, 1'b1);
    step("fill_a3", 1'b1, DW'(32'hA3), 1'b0, 1'b1, 1'b1);
    step("fill_a4", 1'b1, DW'(32'hA4), 1'b0, 1'b1, 1'b1);
    // Full with a simultaneous pop: the write is still refused.
    step("full_pop_wr", 1'b1, DW'(32'hA5), 1'b1, 1'b1, 1'b1);
    // Refill to full once more, then drain past empty.
    step("refill_a6", 1'b1, DW'(32'hA6), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("drain", 1'b0, '0, 1'b1, 1'b1, 1'b1);
    end

    // Steady stream with read always high.
    for (int i = 1; i <= 16; i++) begin
      step("stream", 1'b1, DW'(i), 1'b1, 1'b1, 1'b1);
    end
    step("stream_tail", 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step("stream_tail2", 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Clock-enable gating with two entries queued.
    step("gate_fill1", 1'b1, DW'(32'hC1), 1'b0, 1'b1, 1'b1);
    step("gate_fill2", 1'b1, DW'(32'hC2), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("gate", 1'b1, DW'(32'hCC), 1'b1, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges with two entries queued.
    if_write = 1'b0;
    if_read  = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    sb.delete();
    check("arst_empty_n", DW'(if_empty_n), '0);
    check("arst_full_n", DW'(if_full_n), DW'(1));
    check("arst_dout", if_dout, '0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    step("arst_idle", 1'b0, '0, 1'b0, 1'b1, 1'b1);
    step("arst_wr_b1", 1'b1, DW'(32'hB1), 1'b0, 1'b1, 1'b1);
    step("arst_rd_b1", 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step("arst_end", 1'b0, '0, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/linear_layer_fifo_srl_fwft.md
Name: linear_layer_fifo_srl_fwft

Overview:
- Complete shift-register FIFO for the Linear_Layer dataflow channels. It wraps SRL-style storage with its write controller and its read-side controller.
- The read side adds a registered first-word-fall-through (FWFT) output stage, so consumers see registered data and valid. No combinational addr-to-dout path reaches the consumer.
- Sits between a producer task and a consumer task. Uses the standard if_* handshake on both ends.

Parameters:
- DATA_WIDTH, 304, width of each entry.
- ADDR_WIDTH, 2, width of the SRL read address. DEPTH must be ≤ 2^ADDR_WIDTH, and ADDR_WIDTH must be ≥ 1.
- DEPTH, 2, number of SRL entries. Total capacity is DEPTH+1 (SRL entries plus the output register).

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- reset_n, input, 1, asynchronous active-low reset.
- if_write_ce, input, 1, write clock enable.
- if_write, input, 1, write request.
- if_din, input, DATA_WIDTH, write data.
- if_full_n, output, 1, high when a write can be accepted.
- if_read_ce, input, 1, read clock enable.
- if_read, input, 1, read request / pop.
- if_dout, output, DATA_WIDTH, head-of-queue data (registered).
- if_empty_n, output, 1, high when if_dout is valid.

Behaviour:
- Internal state:
  - SRL array of DEPTH entries (not reset).
  - cnt, ADDR_WIDTH+1 bits, SRL occupancy 0..DEPTH.
  - out_valid, 1 bit.
  - out_data, DATA_WIDTH bits.
- Reset (async, while reset_n=0): cnt=0, out_valid=0, out_data=0. Hence if_empty_n=0, if_full_n=1, if_dout=0. SRL contents are don't-care.
- Output mapping:
  - if_full_n = (cnt < DEPTH), combinational from the cnt register.
  - if_empty_n = out_valid.
  - if_dout = out_data.
- push = if_write & if_write_ce & if_full_n. Writes while full are silently dropped.
- pop = if_read & if_read_ce & out_valid. Reads while empty are ignored.
- refill = !out_valid | pop; the output register takes new data this edge.
- Per rising edge, in priority order:
  - refill & cnt>0: out_data <= SRL[cnt-1] (pre-shift value); out_valid <= 1.
    - If push also occurs: shift in if_din; cnt unchanged.
    - Otherwise: cnt <= cnt-1.
  - refill & cnt==0 & push: bypass, out_data <= if_din, out_valid <= 1. SRL untouched, cnt stays 0.
  - refill & cnt==0 & !push: out_valid <= 0; out_data holds its last value.
  - !refill & push: shift in if_din (SRL[0] <= din, SRL[i+1] <= SRL[i]); cnt <= cnt+1.
  - otherwise: hold.
- Latency: a write into an empty FIFO is visible (if_empty_n=1, if_dout=data) one cycle later. Pop-to-next-head is also one cycle.
- Throughput: one push and one pop per cycle in any non-empty, non-full state. Strict FIFO order is always preserved.
- Full boundary: cnt==DEPTH forces if_full_n=0 even in a cycle that also pops. A write in that cycle is not accepted; the freed slot is visible on the next cycle.
- Reset mid-operation: all queued data is discarded immediately, asynchronously. Outputs go to reset values without waiting for clk.

Optional Feature:
- Macro LINEAR_LAYER_FIFO_OCCUPANCY_EN.
- Defined: adds output port if_num_data, width ADDR_WIDTH+1, value cnt + out_valid (range 0..DEPTH+1). It is registered-state derived, updates on the same edge as cnt and out_valid, and is 0 in reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (DATA_WIDTH=304, DEPTH=2):
- Reset: hold reset_n=0, drive if_write=1 -> if_empty_n=0, if_full_n=1, if_dout=0, no data accepted. Release -> still empty.
- Single write 0xA1, if_read=0 -> next cycle if_empty_n=1, if_dout=0xA1, if_full_n=1; SRL bypassed (occupancy 1).
- Writes 0xA1, 0xA2, 0xA3 back-to-back, no reads -> after third, if_full_n=0, if_dout=0xA1 (occupancy 3). 4th write 0xA4 dropped. Then continuous reads -> if_dout A1, A2, A3 on consecutive cycles, then if_empty_n=0; A4 never appears.
- Steady stream: write 0x01..0x10 one per cycle with if_read=1 always -> output 0x01..0x10 in order, one per cycle, after 1-cycle latency; if_full_n stays 1.
- Gating: if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0 -> no state change over 5 cycles.
- Async reset mid-operation with 2 entries queued, asserted between clock edges -> if_empty_n=0 and if_full_n=1 before the next edge. After release, a write of 0xB1 emerges first, with no stale data.
